// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel enable from clk, h/v counters, syncs, blank, strobes.
// Optional sticky line interrupt is built only when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen #(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33,
  parameter int CLK_DIV = 2,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int XW      = 11,
  parameter int YW      = 10,
  parameter int FW      = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          pix_ce,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          VGA_SYNC_n,
  output logic          sof,
  output logic          eol,
  output logic [FW-1:0] frame_cnt,
  input  logic [YW-1:0] irq_line,
  input  logic          irq_ack,
  output logic          line_irq
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
  localparam int DW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [XW-1:0] H_LAST   = XW'(HTOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(HACTIVE);
  localparam logic [XW-1:0] HS_FIRST = XW'(HACTIVE + HFP);
  localparam logic [XW-1:0] HS_LAST  = XW'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(VTOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(VACTIVE);
  localparam logic [YW-1:0] VS_FIRST = YW'(VACTIVE + VFP);
  localparam logic [YW-1:0] VS_LAST  = YW'(VACTIVE + VFP + VSYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pix_ce_q, pix_ce_d;
  logic          vga_clk_q, vga_clk_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  // Raster counters: enable low parks everything at the top-left corner.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (!enable) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
      end else begin
        h_d = h_q + XW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Registered decodes of the current counter state; all share one clk of latency.
  always_comb begin
    x_d         = h_q;
    y_d         = v_q;
    pix_ce_d    = enable && (div_q == DIV_LAST);
    vga_clk_d   = (div_q >= DIV_HALF);
    blank_n_d   = enable && (h_q < H_ACT) && (v_q < V_ACT);
    hs_d        = (enable && (h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d        = (enable && (v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VS_POL : ~VS_POL;
    sof_d       = enable && (div_q == '0) && (h_q == '0) && (v_q == '0);
    eol_d       = enable && (div_q == DIV_LAST) && (h_q == H_LAST);
    frame_cnt_d = sof_d ? frame_cnt_q + FW'(1) : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_ce_q    <= 1'b0;
      vga_clk_q   <= 1'b0;
      blank_n_q   <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_ce_q    <= pix_ce_d;
      vga_clk_q   <= vga_clk_d;
      blank_n_q   <= blank_n_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic          line_irq_q, line_irq_d;
  logic [YW-1:0] irq_prev;
  logic          irq_valid;

  // Fires on the eol that ends the line before irq_line; set beats a same-clk ack.
  always_comb begin
    irq_valid  = (int'(irq_line) < VTOTAL);
    irq_prev   = (irq_line == '0) ? V_LAST : irq_line - YW'(1);
    line_irq_d = line_irq_q;
    if (irq_ack) line_irq_d = 1'b0;
    if (irq_valid && eol_q && (y_q == irq_prev)) line_irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) line_irq_q <= 1'b0;
    else          line_irq_q <= line_irq_d;
  end

  assign line_irq = line_irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_line, irq_ack};
  assign line_irq   = 1'b0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign pix_ce      = pix_ce_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_n = blank_n_q;
  assign VGA_SYNC_n  = 1'b0;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 raster (line timing, enable park, reset) and a tiny raster (full frames, irq).
module tb_vga_timing_gen;

`ifdef VGA_TIMING_LINE_IRQ_EN
  localparam int IRQ_EN = 1;
`else
  localparam int IRQ_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst0_n, en0, ack0;
  logic [9:0]  irq_line0;
  logic [10:0] x0;
  logic [9:0]  y0;
  logic        pix0, vclk0, hs0, vs0, blank0, sync_n0, sof0, eol0, irq0;
  logic [15:0] frame0;

  // small instance: HTOTAL 14, VTOTAL 8, CLK_DIV 4, HS active-high
  logic        rst1_n, en1, ack1;
  logic [3:0]  irq_line1;
  logic [3:0]  x1;
  logic [3:0]  y1;
  logic        pix1, vclk1, hs1, vs1, blank1, sync_n1, sof1, eol1, irq1;
  logic [3:0]  frame1;

  vga_timing_gen dut0 (
    .clk(clk), .reset_n(rst0_n), .enable(en0), .x(x0), .y(y0), .pix_ce(pix0),
    .VGA_CLK(vclk0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_n(blank0), .VGA_SYNC_n(sync_n0),
    .sof(sof0), .eol(eol0), .frame_cnt(frame0), .irq_line(irq_line0), .irq_ack(ack0),
    .line_irq(irq0)
  );

  vga_timing_gen #(
    .HACTIVE(8), .HFP(2), .HSYNC(2), .HBP(2),
    .VACTIVE(4), .VFP(1), .VSYNC(2), .VBP(1),
    .CLK_DIV(4), .HS_POL(1'b1), .VS_POL(1'b0),
    .XW(4), .YW(4), .FW(4)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .enable(en1), .x(x1), .y(y1), .pix_ce(pix1),
    .VGA_CLK(vclk1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_n(blank1), .VGA_SYNC_n(sync_n1),
    .sof(sof1), .eol(eol1), .frame_cnt(frame1), .irq_line(irq_line1), .irq_ack(ack1),
    .line_irq(irq1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
  endtask

  int blank_n, hs_n, hs_first, hs_last, pce_n, eol_n, eol_x, vs_n, sof_extra;
  int c0_vclk, c0_pix, c1_vclk, c1_pix;
  int clk_err, pce_err, blank_late, vs_first, irq_first, irq_n;
  bit found;

  initial begin
    rst0_n = 1'b0; en0 = 1'b1; ack0 = 1'b0; irq_line0 = 10'd100;
    rst1_n = 1'b0; en1 = 1'b1; ack1 = 1'b0; irq_line1 = 4'd3;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_x", int'(x0), 0);
    chk("rst_y", int'(y0), 0);
    chk("rst_vclk", int'(vclk0), 0);
    chk("rst_pix_ce", int'(pix0), 0);
    chk("rst_sof", int'(sof0), 0);
    chk("rst_eol", int'(eol0), 0);
    chk("rst_blank", int'(blank0), 0);
    chk("rst_hs", int'(hs0), 1);
    chk("rst_vs", int'(vs0), 1);
    chk("rst_frame", int'(frame0), 0);
    chk("rst_irq", int'(irq0), 0);
    chk("rst_hs_pol1", int'(hs1), 0);
    chk("sync_n", int'(sync_n0), 0);

    // default line 0
    rst0_n = 1'b1;
    @(negedge clk);
    chk("sof_after_release", int'(sof0), 1);
    chk("frame_after_release", int'(frame0), 1);
    chk("blank_line0_start", int'(blank0), 1);
    blank_n = 0; hs_n = 0; hs_first = -1; hs_last = -1; pce_n = 0; eol_n = 0; eol_x = -1;
    vs_n = 0; sof_extra = 0;
    for (int c = 0; c < 1600; c++) begin
      if (blank0) blank_n++;
      if (!hs0) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(x0);
        hs_last = int'(x0);
      end
      if (pix0) pce_n++;
      if (eol0) begin eol_n++; eol_x = int'(x0); end
      if (!vs0) vs_n++;
      if (c > 0 && sof0) sof_extra++;
      if (c == 0) begin c0_vclk = int'(vclk0); c0_pix = int'(pix0); end
      if (c == 1) begin c1_vclk = int'(vclk0); c1_pix = int'(pix0); end
      @(negedge clk);
    end
    chk("l0_blank_clks", blank_n, 1280);
    chk("l0_hs_clks", hs_n, 192);
    chk("l0_hs_first_x", hs_first, 656);
    chk("l0_hs_last_x", hs_last, 751);
    chk("l0_pix_ce_n", pce_n, 800);
    chk("l0_eol_n", eol_n, 1);
    chk("l0_eol_x", eol_x, 799);
    chk("l0_vs_low", vs_n, 0);
    chk("l0_sof_extra", sof_extra, 0);
    chk("c0_vclk", c0_vclk, 0);
    chk("c0_pix_ce", c0_pix, 0);
    chk("c1_vclk", c1_vclk, 1);
    chk("c1_pix_ce", c1_pix, 1);
    chk("l1_x", int'(x0), 0);
    chk("l1_y", int'(y0), 1);

    // enable dropped at x = 300
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (x0 == 11'd300) found = 1'b1;
      else @(negedge clk);
    end
    chk("wait_x300", int'(found), 1);
    en0 = 1'b0;
    blank_n = 0; hs_n = 0; vs_n = 0; sof_extra = 0; pce_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (blank0) blank_n++;
      if (hs0) hs_n++;
      if (vs0) vs_n++;
      if (sof0) sof_extra++;
      if (pix0) pce_n++;
    end
    chk("park_blank", blank_n, 0);
    chk("park_hs_inactive", hs_n, 10);
    chk("park_vs_inactive", vs_n, 10);
    chk("park_sof", sof_extra, 0);
    chk("park_pix_ce", pce_n, 0);
    chk("park_x", int'(x0), 0);
    chk("park_frame_hold", int'(frame0), 1);
    en0 = 1'b1;
    @(negedge clk);
    chk("restart_sof", int'(sof0), 1);
    chk("restart_x", int'(x0), 0);
    chk("restart_y", int'(y0), 0);
    chk("restart_frame", int'(frame0), 2);

    // async reset mid-line
    repeat (50) @(negedge clk);
    chk("pre_reset_x", int'(x0 != 11'd0), 1);
    rst0_n = 1'b0;
    #1;
    chk("midrst_x", int'(x0), 0);
    chk("midrst_frame", int'(frame0), 0);
    chk("midrst_hs", int'(hs0), 1);
    chk("midrst_blank", int'(blank0), 0);
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    chk("midrst_sof", int'(sof0), 1);
    chk("midrst_frame1", int'(frame0), 1);

    // small raster: one whole frame
    rst1_n = 1'b1;
    @(negedge clk);
    chk("s_sof", int'(sof1), 1);
    clk_err = 0; pce_err = 0; hs_n = 0; eol_n = 0; blank_n = 0; blank_late = 0;
    vs_n = 0; vs_first = -1; sof_extra = 0; irq_first = -1;
    for (int c = 0; c < 448; c++) begin
      if (int'(vclk1) != int'((c % 4) >= 2)) clk_err++;
      if (int'(pix1) != int'((c % 4) == 3)) pce_err++;
      if (c < 56 && hs1) hs_n++;
      if (eol1) eol_n++;
      if (blank1) blank_n++;
      if (blank1 && y1 >= 4'd4) blank_late++;
      if (!vs1) begin
        vs_n++;
        if (vs_first < 0) vs_first = int'(y1);
      end
      if (c > 0 && sof1) sof_extra++;
      if (irq1 && irq_first < 0) irq_first = c;
      @(negedge clk);
    end
    chk("s_vclk_pattern_err", clk_err, 0);
    chk("s_pix_ce_pattern_err", pce_err, 0);
    chk("s_l0_hs_high_clks", hs_n, 8);
    chk("s_eol_per_frame", eol_n, 8);
    chk("s_blank_clks", blank_n, 128);
    chk("s_blank_below_active", blank_late, 0);
    chk("s_vs_low_clks", vs_n, 112);
    chk("s_vs_first_y", vs_first, 5);
    chk("s_sof_extra", sof_extra, 0);
    chk("s_irq_first_clk", irq_first, IRQ_EN ? 168 : -1);
    chk("s_sof2", int'(sof1), 1);
    chk("s_frame2", int'(frame1), 2);
    chk("s_frame2_x", int'(x1), 0);
    chk("s_irq_sticky", int'(irq1), IRQ_EN);

    // lone ack clears
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    chk("s_irq_ack_clear", int'(irq1), 0);

    // ack coinciding with set
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (eol1 && y1 == 4'd2) found = 1'b1;
    end
    chk("wait_eol_y2", int'(found), 1);
    chk("s_irq_before_set", int'(irq1), 0);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    chk("s_irq_set_wins", int'(irq1), IRQ_EN);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    irq_line1 = 4'd9;
    chk("s_irq_clear2", int'(irq1), 0);

    // irq_line beyond VTOTAL never fires
    irq_n = 0;
    for (int i = 0; i < 448; i++) begin
      @(negedge clk);
      if (irq1) irq_n++;
    end
    chk("s_irq_out_of_range", irq_n, 0);

    // irq_line 0 fires on eol of the last line
    irq_line1 = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (eol1 && y1 == 4'd7) found = 1'b1;
    end
    chk("wait_eol_y7", int'(found), 1);
    chk("s_irq0_before", int'(irq1), 0);
    @(negedge clk);
    chk("s_irq0_fire", int'(irq1), IRQ_EN);
    chk("s_irq0_sof", int'(sof1), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next-generation replacement for the fixed 640x480 counter block inside the accelerator top level. It derives a pixel clock enable from the system clock and runs horizontal/vertical counters with fully parametrised porches, sync widths and sync polarity. It emits sync, blank, pixel coordinates, start-of-frame/end-of-line strobes and a frame counter. It sits between the system clock domain and the pixel/framebuffer logic.

## Interface
- HACTIVE, 640, visible pixels per line
- HFP / HSYNC / HBP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- VACTIVE, 480, visible lines
- VFP / VSYNC / VBP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- CLK_DIV, 2, system clocks per pixel; must be >= 2
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- XW / YW, 11 / 10, coordinate widths; must hold HTOTAL-1 / VTOTAL-1
- FW, 16, frame counter width
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run counters; low = synchronous park
- x  out  XW  registered horizontal count, 0..HTOTAL-1
- y  out  YW  registered vertical count, 0..VTOTAL-1
- pix_ce  out  1  one-clk pixel enable
- VGA_CLK  out  1  pixel clock to the DAC
- VGA_HS / VGA_VS  out  1  syncs, polarity per HS_POL/VS_POL
- VGA_BLANK_n  out  1  high in the active region
- VGA_SYNC_n  out  1  constant 0
- sof / eol  out  1  one-clk start-of-frame / end-of-line strobes
- frame_cnt  out  FW  frames started, wraps at 2^FW
- irq_line  in  YW  line number that raises line_irq
- irq_ack  in  1  clears line_irq
- line_irq  out  1  sticky line interrupt

## Operation
- HTOTAL = HACTIVE+HFP+HSYNC+HBP; VTOTAL = VACTIVE+VFP+VSYNC+VBP.
- div counter: 0..CLK_DIV-1, wraps to 0. pix_ce = (div == CLK_DIV-1).
- VGA_CLK = (div >= CLK_DIV/2), so its rising edge falls mid-pixel.
- h counter: advances on pix_ce and wraps HTOTAL-1 -> 0. v counter: advances when h wraps and wraps VTOTAL-1 -> 0.
- Region order per axis: active, front porch, sync, back porch.
- HS is active for h in [HACTIVE+HFP, HACTIVE+HFP+HSYNC-1]; VS likewise on v.
- VGA_BLANK_n = (h < HACTIVE) && (v < VACTIVE).
- sof = enable && h==0 && v==0 && div==0. frame_cnt increments on each sof.
- eol = pix_ce && h == HTOTAL-1.
- enable low: div, h and v clear to 0. VGA_BLANK_n = 0 and syncs are inactive. frame_cnt holds. When enable rises, the frame restarts at (0,0) and sof fires.
- No other states; the design is a free-running raster.

## Timing
- Reset values (async): div, h, v, x, y = 0; VGA_CLK, pix_ce, sof, eol, VGA_BLANK_n = 0; VGA_HS = !HS_POL; VGA_VS = !VS_POL; frame_cnt = 0; line_irq = 0.
- x, y, VGA_HS, VGA_VS, VGA_BLANK_n, sof and eol are registered decodes of the counter state. Each is valid exactly one clk after the counter state it describes. pix_ce and VGA_CLK carry the same one-clk delay, so all outputs stay mutually aligned.
- Reset mid-frame: all outputs return to their reset values immediately. After release, the first clk with enable high produces sof, and frame_cnt becomes 1.
- Frame length = HTOTAL*VTOTAL*CLK_DIV clks. With the defaults: 800*525*2 = 840000.

## Configuration
- VGA_TIMING_LINE_IRQ_EN defined:
  - line_irq sets when eol fires on line v == irq_line-1 (mod VTOTAL), i.e. on entry to line irq_line.
  - line_irq clears on irq_ack.
  - If set and ack occur in the same clk, set wins.
  - An irq_line value >= VTOTAL never fires.
- Not defined: line_irq is tied to 0, irq_line and irq_ack are ignored, and no interrupt flops are synthesised.

## Test plan
- Defaults, reset then enable = 1 -> sof one clk after release; next sof 840000 clks later; frame_cnt = 2.
- Defaults, line 0 -> VGA_BLANK_n high for 1280 clks per line. VGA_HS low for exactly 192 clks, starting at x = 656 and ending after x = 751.
- Defaults -> VGA_VS low for exactly 2 lines (y = 490, 491), i.e. 3200 clks; VGA_BLANK_n = 0 for every y >= 480.
- HS_POL = 1, CLK_DIV = 4, HACTIVE = 8, all porches = 2 -> line = 56 clks and HS high for 8 clks. pix_ce period is 4; VGA_CLK reads 0,0,1,1.
- enable dropped mid-line (x = 300) for 10 clks, then raised -> outputs blanked with syncs inactive while low. x = y = 0 and sof on restart; frame_cnt +1.
- With VGA_TIMING_LINE_IRQ_EN and irq_line = 100 -> line_irq rises one clk after the eol of line 99. irq_ack asserted on a set cycle leaves it high; a lone irq_ack clears it. Without the macro, line_irq stays 0.
